// File: rtl/trena_uc_multi_if.sv
// Handshake bundle between the trena control unit (slave) and the
// measurement/transmit datapath or bench that drives it (master).
interface trena_uc_multi_if #(
   parameter int N_CHANNELS = 2,
   parameter int N_DIGITS   = 4
);
   localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int DG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic            mensurar;
   logic            continuo;
   logic            parar;
   logic            pronto;
   logic            tx_pronto;

   logic            zera;
   logic            comeca_medida;
   logic [CH_W-1:0] canal;
   logic [DG_W-1:0] digito;
   logic            envia;
   logic            fim;
   logic            erro;
   logic [3:0]      db_estado;

   modport master (
      output mensurar, continuo, parar, pronto, tx_pronto,
      input  zera, comeca_medida, canal, digito, envia, fim, erro, db_estado
   );

   modport slave (
      input  mensurar, continuo, parar, pronto, tx_pronto,
      output zera, comeca_medida, canal, digito, envia, fim, erro, db_estado
   );
endinterface

// File: rtl/trena_uc_multi.sv
// Control unit that sweeps N sensor channels: trigger, wait for pronto with a
// timeout, then send N_DIGITS characters per channel; single or continuous sweeps.
module trena_uc_multi #(
   parameter int N_CHANNELS     = 2,
   parameter int N_DIGITS       = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic             clock,
   input  logic             reset,
   trena_uc_multi_if.slave  bus
);
   localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int DG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);
   localparam logic [DG_W-1:0] LAST_DG = DG_W'(N_DIGITS - 1);
   localparam logic [TO_W-1:0] LAST_TO = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      INICIAL   = 4'd0,
      PREPARA   = 4'd1,
      DISPARA   = 4'd2,
      AGUARDA   = 4'd3,
      TRANSMITE = 4'd4,
      ESPERA    = 4'd5,
      PROXIMO   = 4'd6,
      FINAL     = 4'd7,
      TIMEOUT   = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [CH_W-1:0] canal_q, canal_d;
   logic [DG_W-1:0] digito_q, digito_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            erro_q, erro_d;
   logic            mode_c_q, mode_c_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= INICIAL;
         canal_q  <= '0;
         digito_q <= '0;
         cnt_q    <= '0;
         erro_q   <= 1'b0;
         mode_c_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         canal_q  <= canal_d;
         digito_q <= digito_d;
         cnt_q    <= cnt_d;
         erro_q   <= erro_d;
         mode_c_q <= mode_c_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      canal_d  = canal_q;
      digito_d = digito_q;
      cnt_d    = cnt_q;
      erro_d   = erro_q;
      mode_c_d = mode_c_q;

      case (state_q)
         INICIAL: begin
            if (bus.mensurar) begin
               mode_c_d = bus.continuo;
               state_d  = PREPARA;
            end
         end
         PREPARA: begin
            canal_d  = '0;
            digito_d = '0;
            erro_d   = 1'b0;
            state_d  = DISPARA;
         end
         DISPARA: begin
            cnt_d   = '0;
            state_d = AGUARDA;
         end
         AGUARDA: begin
            // pronto takes priority over the terminal count on the same cycle
            cnt_d = cnt_q + 1'b1;
            if (bus.pronto) begin
               state_d = TRANSMITE;
            end else if (cnt_q == LAST_TO) begin
               state_d = TIMEOUT;
            end
         end
         TRANSMITE: begin
            state_d = ESPERA;
         end
         ESPERA: begin
            if (bus.tx_pronto) begin
               if (digito_q < LAST_DG) begin
                  digito_d = digito_q + 1'b1;
                  state_d  = TRANSMITE;
               end else begin
                  digito_d = '0;
                  state_d  = PROXIMO;
               end
            end
         end
         PROXIMO: begin
            // parar is only looked at here, so a running sweep always finishes
            if (canal_q < LAST_CH) begin
               canal_d = canal_q + 1'b1;
               state_d = DISPARA;
            end else begin
               canal_d = '0;
               state_d = (mode_c_q && !bus.parar) ? DISPARA : FINAL;
            end
         end
         TIMEOUT: begin
            erro_d  = 1'b1;
            state_d = PROXIMO;
         end
         FINAL: begin
            state_d = INICIAL;
         end
         default: begin
            state_d = INICIAL;
         end
      endcase
   end

   always_comb begin
      bus.zera          = 1'b0;
      bus.comeca_medida = 1'b0;
      bus.envia         = 1'b0;
      bus.fim           = 1'b0;
      bus.db_estado     = 4'hF;

      case (state_q)
         INICIAL, PREPARA: bus.zera          = 1'b1;
         DISPARA:          bus.comeca_medida = 1'b1;
         TRANSMITE:        bus.envia         = 1'b1;
         FINAL:            bus.fim           = 1'b1;
         default:          ;
      endcase

      if (state_q <= TIMEOUT) begin
         bus.db_estado = state_q;
      end
   end

   assign bus.canal  = canal_q;
   assign bus.digito = digito_q;
   assign bus.erro   = erro_q;

endmodule

// File: tb/tb_trena_uc_multi.sv
// Self-checking bench for trena_uc_multi: a cycle-by-cycle vector table for the
// basic sequencing, then reactive sessions for sweep, timeout, coincidence and continuous modes.
module tb_trena_uc_multi;
   logic clock = 1'b0;
   logic reset = 1'b0;

   int checks   = 0;
   int failures = 0;

   trena_uc_multi_if #(.N_CHANNELS(2), .N_DIGITS(4)) bus ();

   trena_uc_multi #(
      .N_CHANNELS(2),
      .N_DIGITS(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst_n;
      logic       mensurar;
      logic       continuo;
      logic       parar;
      logic       pronto;
      logic       tx_pronto;
      logic [3:0] st;
      logic       zera;
      logic       comeca;
      logic       envia;
      logic       fim;
      logic [0:0] canal;
      logic [1:0] digito;
      logic       erro;
   } vec_t;

   vec_t vecs[$];

   int n_comeca, n_envia, n_fim, aguarda_cnt;
   logic to_seen, erro_drop, erro_at_fim, erro_first, sess_done;
   logic [0:0] env_canal [32];
   logic [1:0] env_dig   [32];

   function automatic vec_t mk(input logic r, m, c, p, pr, tx,
                               input logic [3:0] st, input logic z, cm, en, f,
                               input logic [0:0] ca, input logic [1:0] dg, input logic er);
      vec_t v;
      v.rst_n = r; v.mensurar = m; v.continuo = c; v.parar = p;
      v.pronto = pr; v.tx_pronto = tx;
      v.st = st; v.zera = z; v.comeca = cm; v.envia = en; v.fim = f;
      v.canal = ca; v.digito = dg; v.erro = er;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      reset         = v.rst_n;
      bus.mensurar  = v.mensurar;
      bus.continuo  = v.continuo;
      bus.parar     = v.parar;
      bus.pronto    = v.pronto;
      bus.tx_pronto = v.tx_pronto;
   endtask

   // One reactive session: pronto pr_delay cycles after each comeca_medida
   // (never on channel 0 when skip_ch0), tx_pronto 2 cycles after each envia,
   // parar raised on the channel-1 envia of the stop_comeca-th measurement.
   task automatic run_sweep(input int pr_delay, input logic cont, input logic skip_ch0,
                            input int stop_comeca, input int max_cycles);
      int pr_cnt = 0;
      int tx_cnt = 0;
      n_comeca = 0; n_envia = 0; n_fim = 0; aguarda_cnt = 0;
      to_seen = 1'b0; erro_drop = 1'b0; erro_at_fim = 1'b0; erro_first = 1'b1;
      sess_done = 1'b0;
      bus.mensurar = 1'b1; bus.continuo = cont; bus.parar = 1'b0;
      bus.pronto = 1'b0; bus.tx_pronto = 1'b0;
      for (int cyc = 0; cyc < max_cycles && !sess_done; cyc++) begin
         @(posedge clock); #1;
         bus.mensurar = 1'b0; bus.pronto = 1'b0; bus.tx_pronto = 1'b0;
         if (pr_cnt > 0) begin
            pr_cnt--;
            if (pr_cnt == 0) bus.pronto = 1'b1;
         end
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) bus.tx_pronto = 1'b1;
         end
         if (bus.comeca_medida) begin
            if (n_comeca == 0) erro_first = bus.erro;
            n_comeca++;
            if (!(skip_ch0 && bus.canal == 1'b0)) pr_cnt = pr_delay;
         end
         if (bus.db_estado == 4'd3 && !to_seen) aguarda_cnt++;
         if (to_seen && !bus.erro) erro_drop = 1'b1;
         if (bus.db_estado == 4'd8) to_seen = 1'b1;
         if (bus.envia) begin
            if (n_envia < 32) begin
               env_canal[n_envia] = bus.canal;
               env_dig[n_envia]   = bus.digito;
            end
            n_envia++;
            tx_cnt = 2;
            if (stop_comeca != 0 && n_comeca == stop_comeca && bus.canal == 1'b1) bus.parar = 1'b1;
         end
         if (bus.fim) begin
            n_fim++;
            erro_at_fim = bus.erro;
            sess_done = 1'b1;
         end
      end
      check_output("session_reached_fim", sess_done, 1);
      bus.parar = 1'b0; bus.pronto = 1'b0; bus.tx_pronto = 1'b0;
   endtask

   task automatic check_envia_log(input string name, input int count, input logic only_ch1);
      for (int i = 0; i < count && i < 32; i++) begin
         check_output($sformatf("%s_canal%0d", name, i), env_canal[i], only_ch1 ? 1 : (i / 4) % 2);
         check_output($sformatf("%s_digito%0d", name, i), env_dig[i], i % 4);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.mensurar = 1'b0; bus.continuo = 1'b0; bus.parar = 1'b0;
      bus.pronto = 1'b0; bus.tx_pronto = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      //          r m c p pr tx  st z cm en f  ca dg er
      vecs.push_back(mk(0,1,0,0,0,0, 0,1,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,1,1, 0,1,0,0,0, 0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,1,1, 2,0,1,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,1,1, 3,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 3,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,1,0, 4,0,0,1,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1, 5,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1, 4,0,0,1,0, 0,1,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1, 4,0,0,1,0, 0,2,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 0,2,0));
      vecs.push_back(mk(1,0,0,0,0,1, 4,0,0,1,0, 0,3,0));
      vecs.push_back(mk(1,0,0,0,1,0, 5,0,0,0,0, 0,3,0));
      vecs.push_back(mk(1,0,0,0,0,1, 6,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0, 2,0,1,0,0, 1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 3,0,0,0,0, 1,0,0));
      vecs.push_back(mk(1,0,0,0,1,0, 4,0,0,1,0, 1,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 1,0,0));
      vecs.push_back(mk(1,0,0,0,0,1, 4,0,0,1,0, 1,1,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 1,1,0));
      vecs.push_back(mk(1,0,0,0,0,1, 4,0,0,1,0, 1,2,0));
      vecs.push_back(mk(1,0,0,0,0,0, 5,0,0,0,0, 1,2,0));

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i]);
         @(posedge clock); #1;
         check_output($sformatf("vec%0d_state", i),  bus.db_estado,     vecs[i].st);
         check_output($sformatf("vec%0d_zera", i),   bus.zera,          vecs[i].zera);
         check_output($sformatf("vec%0d_comeca", i), bus.comeca_medida, vecs[i].comeca);
         check_output($sformatf("vec%0d_envia", i),  bus.envia,         vecs[i].envia);
         check_output($sformatf("vec%0d_fim", i),    bus.fim,           vecs[i].fim);
         check_output($sformatf("vec%0d_canal", i),  bus.canal,         vecs[i].canal);
         check_output($sformatf("vec%0d_digito", i), bus.digito,        vecs[i].digito);
         check_output($sformatf("vec%0d_erro", i),   bus.erro,          vecs[i].erro);
      end

      // Asynchronous reset mid-cycle while in ESPERA at canal 1, digito 2.
      bus.tx_pronto = 1'b0; bus.pronto = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_output("async_rst_state",  bus.db_estado,     0);
      check_output("async_rst_zera",   bus.zera,          1);
      check_output("async_rst_comeca", bus.comeca_medida, 0);
      check_output("async_rst_envia",  bus.envia,         0);
      check_output("async_rst_fim",    bus.fim,           0);
      check_output("async_rst_canal",  bus.canal,         0);
      check_output("async_rst_digito", bus.digito,        0);
      check_output("async_rst_erro",   bus.erro,          0);
      repeat (3) begin
         @(posedge clock); #1;
         check_output("in_rst_no_fim", bus.fim, 0);
      end
      reset = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         check_output("after_rst_waits", bus.db_estado, 0);
         check_output("after_rst_no_fim", bus.fim, 0);
      end

      // Single sweep, normal responses.
      run_sweep(3, 1'b0, 1'b0, 0, 400);
      check_output("single_comeca", n_comeca, 2);
      check_output("single_envia", n_envia, 8);
      check_output("single_fim", n_fim, 1);
      check_output("single_erro", erro_at_fim, 0);
      check_output("single_no_timeout", to_seen, 0);
      check_envia_log("single", 8, 1'b0);
      @(posedge clock); #1;
      check_output("single_back_inicial", bus.db_estado, 0);

      // Channel 0 never answers: timeout, channel 1 still served.
      run_sweep(3, 1'b0, 1'b1, 0, 400);
      check_output("to_seen", to_seen, 1);
      check_output("to_aguarda_cycles", aguarda_cnt, 16);
      check_output("to_comeca", n_comeca, 2);
      check_output("to_envia", n_envia, 4);
      check_output("to_fim", n_fim, 1);
      check_output("to_erro_at_fim", erro_at_fim, 1);
      check_output("to_erro_held", erro_drop, 0);
      check_envia_log("to", 4, 1'b1);
      repeat (4) begin
         @(posedge clock); #1;
         check_output("to_erro_sticky_idle", bus.erro, 1);
      end
      check_output("to_idle_state", bus.db_estado, 0);

      // pronto on the terminal-count cycle wins; PREPARA clears old erro.
      run_sweep(16, 1'b0, 1'b0, 0, 400);
      check_output("coin_erro_cleared", erro_first, 0);
      check_output("coin_no_timeout", to_seen, 0);
      check_output("coin_envia", n_envia, 8);
      check_output("coin_erro_at_fim", erro_at_fim, 0);
      check_envia_log("coin", 8, 1'b0);
      @(posedge clock); #1;

      // Continuous mode, parar during channel 1 of the second sweep.
      run_sweep(3, 1'b1, 1'b0, 4, 800);
      check_output("cont_comeca", n_comeca, 4);
      check_output("cont_envia", n_envia, 16);
      check_output("cont_fim", n_fim, 1);
      check_output("cont_erro", erro_at_fim, 0);
      check_envia_log("cont", 16, 1'b0);
      @(posedge clock); #1;
      check_output("cont_back_inicial", bus.db_estado, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
